// File: rtl/tx_pkt_arbiter_if.sv
// Bundle between the requester FIFO heads, the packet arbiter and the tx-buffer write port.
// The master modport is the arbiter side. The slave modport is the channel FIFO / tx-buffer side.
interface tx_pkt_arbiter_if #(
  parameter int unsigned NUMCH     = 4,
  parameter int unsigned DATAWIDTH = 8
);
  logic [NUMCH-1:0]           ch_req;
  logic [NUMCH*DATAWIDTH-1:0] ch_data;
  logic [NUMCH-1:0]           ch_datavld;
  logic [NUMCH-1:0]           ch_eop;
  logic [NUMCH-1:0]           ch_rden;
  logic [NUMCH-1:0]           ch_grant;
  logic                       txbuffer_afull;
  logic [DATAWIDTH-1:0]       txbuffer_data;
  logic                       txbuffer_datavld;
  logic                       txbuffer_eop;
  logic                       trunc_pulse;
  logic                       busy;

  modport master (
    input  ch_req, ch_data, ch_datavld, ch_eop, txbuffer_afull,
    output ch_rden, ch_grant, txbuffer_data, txbuffer_datavld, txbuffer_eop,
           trunc_pulse, busy
  );

  modport slave (
    output ch_req, ch_data, ch_datavld, ch_eop, txbuffer_afull,
    input  ch_rden, ch_grant, txbuffer_data, txbuffer_datavld, txbuffer_eop,
           trunc_pulse, busy
  );
endinterface

// File: rtl/tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter for the shared tx-buffer write port.
// It can prepend a channel-ID header and truncates packets longer than MAXPKTLEN payload words.
module tx_pkt_arbiter #(
  parameter int unsigned NUMCH     = 4,
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned MAXPKTLEN = 1500,
  parameter int unsigned HDREN     = 1
) (
  input  logic              dutclk,
  input  logic              reset,
  tx_pkt_arbiter_if.master  bus
);

  localparam int unsigned CHW  = (NUMCH > 1) ? $clog2(NUMCH) : 1;
  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAXPKTLEN - 1);
  localparam logic [CHW-1:0]  LAST_CH  = CHW'(NUMCH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_XFER  = 3'd2,
    S_FLUSH = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CHW-1:0]       rr_q, rr_d;
  logic [CHW-1:0]       gidx_q, gidx_d;
  logic [NUMCH-1:0]     grant_q, grant_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 eop_q, eop_d;
  logic                 trunc_q, trunc_d;
  logic                 busy_q, busy_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  logic [CHW-1:0]       sel_lo, sel_hi, sel_idx;
  logic                 found_lo, found_hi;
  logic [NUMCH-1:0]     sel_onehot;
  logic [DATAWIDTH-1:0] head_data;
  logic                 head_vld, head_eop;
  logic                 xfer_pop, flush_pop;

  // Round robin: take the lowest requester above rr, otherwise wrap to the lowest requester.
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int i = int'(NUMCH) - 1; i >= 0; i--) begin
      if (bus.ch_req[i]) begin
        sel_lo   = CHW'(i);
        found_lo = 1'b1;
        if (CHW'(i) > rr_q) begin
          sel_hi   = CHW'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel_idx = found_hi ? sel_hi : sel_lo;
    sel_onehot = '0;
    for (int i = 0; i < int'(NUMCH); i++) begin
      sel_onehot[i] = (sel_idx == CHW'(i));
    end
  end

  // FIFO head of the granted channel
  always_comb begin
    head_data = '0;
    head_vld  = 1'b0;
    head_eop  = 1'b0;
    for (int i = 0; i < int'(NUMCH); i++) begin
      if (gidx_q == CHW'(i)) begin
        head_data = bus.ch_data[i*DATAWIDTH +: DATAWIDTH];
        head_vld  = bus.ch_datavld[i];
        head_eop  = bus.ch_eop[i];
      end
    end
  end

  assign xfer_pop  = (state_q == S_XFER)  & head_vld & ~bus.txbuffer_afull & ~reset;
  assign flush_pop = (state_q == S_FLUSH) & head_vld & ~reset;

  // The flush drains the truncated tail even under backpressure because nothing is forwarded.
  always_comb begin
    bus.ch_rden = '0;
    for (int i = 0; i < int'(NUMCH); i++) begin
      bus.ch_rden[i] = (gidx_q == CHW'(i)) & (xfer_pop | flush_pop);
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    eop_d   = 1'b0;
    trunc_d = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (found_lo) begin
          gidx_d  = sel_idx;
          grant_d = sel_onehot;
          cnt_d   = '0;
          state_d = (HDREN != 0) ? S_HDR : S_XFER;
        end
      end
      S_HDR: begin
        if (!bus.txbuffer_afull) begin
          data_d  = DATAWIDTH'(gidx_q);
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (xfer_pop) begin
          data_d = head_data;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + CNTW'(1);
          if (head_eop) begin
            eop_d   = 1'b1;
            state_d = S_GAP;
          end else if (cnt_q == LAST_CNT) begin
            eop_d   = 1'b1;
            trunc_d = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (flush_pop && head_eop) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        rr_d    = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge dutclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= LAST_CH;
      gidx_q  <= '0;
      grant_q <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      eop_q   <= 1'b0;
      trunc_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      eop_q   <= eop_d;
      trunc_q <= trunc_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ch_grant         = grant_q;
  assign bus.txbuffer_data    = data_q;
  assign bus.txbuffer_datavld = vld_q;
  assign bus.txbuffer_eop     = eop_q;
  assign bus.trunc_pulse      = trunc_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Directed bench for tx_pkt_arbiter. Channel FIFO heads are modelled with queues.
// Expected tx words go to a scoreboard when a packet is queued.
module tb_tx_pkt_arbiter;

  localparam int unsigned NUMCH = 4;
  localparam int unsigned DW    = 8;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             eop;
    logic [NUMCH-1:0] grant;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             sel;
  logic [NUMCH-1:0] m_req, m_vld, m_eop;
  logic [NUMCH*DW-1:0] m_data;
  logic             m_afull;

  tx_pkt_arbiter_if #(.NUMCH(NUMCH), .DATAWIDTH(DW)) if_a ();
  tx_pkt_arbiter_if #(.NUMCH(NUMCH), .DATAWIDTH(DW)) if_b ();

  tx_pkt_arbiter #(.NUMCH(NUMCH), .DATAWIDTH(DW), .MAXPKTLEN(4), .HDREN(1)) u_a (
    .dutclk(clk), .reset(reset), .bus(if_a)
  );
  tx_pkt_arbiter #(.NUMCH(NUMCH), .DATAWIDTH(DW), .MAXPKTLEN(1500), .HDREN(0)) u_b (
    .dutclk(clk), .reset(reset), .bus(if_b)
  );

  // sel steers the channel model onto one instance and idles the other
  assign if_a.ch_req         = sel ? '0 : m_req;
  assign if_a.ch_data        = sel ? '0 : m_data;
  assign if_a.ch_datavld     = sel ? '0 : m_vld;
  assign if_a.ch_eop         = sel ? '0 : m_eop;
  assign if_a.txbuffer_afull = sel ? 1'b0 : m_afull;
  assign if_b.ch_req         = sel ? m_req : '0;
  assign if_b.ch_data        = sel ? m_data : '0;
  assign if_b.ch_datavld     = sel ? m_vld : '0;
  assign if_b.ch_eop         = sel ? m_eop : '0;
  assign if_b.txbuffer_afull = sel ? m_afull : 1'b0;

  wire [NUMCH-1:0] o_rden  = sel ? if_b.ch_rden : if_a.ch_rden;
  wire [NUMCH-1:0] o_grant = sel ? if_b.ch_grant : if_a.ch_grant;
  wire [DW-1:0]    o_data  = sel ? if_b.txbuffer_data : if_a.txbuffer_data;
  wire             o_vld   = sel ? if_b.txbuffer_datavld : if_a.txbuffer_datavld;
  wire             o_eop   = sel ? if_b.txbuffer_eop : if_a.txbuffer_eop;
  wire             o_trunc = sel ? if_b.trunc_pulse : if_a.trunc_pulse;
  wire             o_busy  = sel ? if_b.busy : if_a.busy;

  logic [DW:0] chq [NUMCH][$];
  exp_t        sbq [$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   trunc_cnt = 0;
  int   last_eop_cyc = -100;
  logic after_eop = 1'b0;
  logic out_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int ch, input int n, input logic [DW-1:0] base,
                          input int maxlen, input bit hdr);
    exp_t          e;
    logic [DW-1:0] d;
    logic          last;
    e.grant = NUMCH'(1 << ch);
    if (hdr) begin
      e.data = DW'(ch);
      e.eop  = 1'b0;
      sbq.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      d    = base + DW'(k);
      last = (k == n - 1);
      chq[ch].push_back({last, d});
      if (k < maxlen) begin
        e.data = d;
        e.eop  = last || (k == maxlen - 1);
        sbq.push_back(e);
      end
    end
  endtask

  task automatic refresh();
    logic [DW:0] w;
    for (int i = 0; i < int'(NUMCH); i++) begin
      if (chq[i].size() > 0) begin
        w = chq[i][0];
        m_req[i] = 1'b1;
        m_vld[i] = 1'b1;
        m_eop[i] = w[DW];
        m_data[i*DW +: DW] = w[DW-1:0];
      end else begin
        m_req[i] = 1'b0;
        m_vld[i] = 1'b0;
        m_eop[i] = 1'b0;
        m_data[i*DW +: DW] = '0;
      end
    end
  endtask

  // One clock: settle inputs, record pops, clock, update FIFOs, check output against the scoreboard.
  task automatic cycle();
    logic [NUMCH-1:0] pop;
    exp_t e;
    refresh();
    #1;
    pop = o_rden;
    if (pop != '0) chk("rden_only_granted", 32'(pop & ~o_grant), 32'(0));
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NUMCH); i++) begin
      if (pop[i] && chq[i].size() > 0) void'(chq[i].pop_front());
    end
    out_vld = o_vld;
    if (o_trunc) begin
      trunc_cnt++;
      chk("trunc_with_eop", 32'({o_vld, o_eop}), 32'(3));
    end
    if (o_vld) begin
      if (sbq.size() == 0) begin
        chk("unexpected_word", 32'(sbq.size()), 32'(1));
      end else begin
        e = sbq.pop_front();
        chk("data", 32'(o_data), 32'(e.data));
        chk("eop", 32'(o_eop), 32'(e.eop));
        chk("grant", 32'(o_grant), 32'(e.grant));
      end
      if (after_eop) chk("interpacket_gap", 32'(cyc - last_eop_cyc >= 3), 32'(1));
      after_eop = o_eop;
      if (o_eop) last_eop_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((sbq.size() != 0 || o_busy) && k < maxc) begin
      cycle();
      k++;
    end
    chk("drain_in_budget", 32'(k < maxc), 32'(1));
  endtask

  task automatic run_until_left(input int left, input int maxc);
    int k = 0;
    while (sbq.size() > left && k < maxc) begin
      cycle();
      k++;
    end
    chk("progress_in_budget", 32'(k < maxc), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    sel     = 1'b0;
    m_afull = 1'b0;
    refresh();
    @(negedge clk);
    cycle();
    cycle();
    // reset state
    chk("rst_vld", 32'(o_vld), 32'(0));
    chk("rst_eop", 32'(o_eop), 32'(0));
    chk("rst_data", 32'(o_data), 32'(0));
    chk("rst_grant", 32'(o_grant), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_trunc", 32'(o_trunc), 32'(0));
    chk("rst_rden", 32'(o_rden), 32'(0));
    reset = 1'b0;

    // single packet on ch2 with header latency
    push_pkt(2, 3, 8'hA1, 4, 1'b1);
    cycle();
    chk("lat_cycle1_vld", 32'(out_vld), 32'(0));
    chk("lat_cycle1_grant", 32'(o_grant), 32'(4'b0100));
    chk("lat_cycle1_busy", 32'(o_busy), 32'(1));
    cycle();
    chk("lat_cycle2_vld", 32'(out_vld), 32'(1));
    drain(30);
    chk("single_busy_end", 32'(o_busy), 32'(0));
    chk("single_grant_end", 32'(o_grant), 32'(0));

    // round robin 0,1,3,0,1,3 after reset
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    push_pkt(0, 2, 8'h10, 4, 1'b1);
    push_pkt(1, 2, 8'h20, 4, 1'b1);
    push_pkt(3, 2, 8'h30, 4, 1'b1);
    push_pkt(0, 2, 8'h18, 4, 1'b1);
    push_pkt(1, 2, 8'h28, 4, 1'b1);
    push_pkt(3, 2, 8'h38, 4, 1'b1);
    drain(80);

    // five cycles of backpressure mid-packet on ch1
    push_pkt(1, 4, 8'hB0, 4, 1'b1);
    run_until_left(2, 20);
    m_afull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      refresh();
      #1;
      chk("bp_rden", 32'(o_rden), 32'(0));
      cycle();
      chk("bp_vld", 32'(out_vld), 32'(0));
      chk("bp_grant", 32'(o_grant), 32'(4'b0010));
    end
    m_afull = 1'b0;
    drain(30);
    chk("bp_fifo_empty", 32'(chq[1].size()), 32'(0));
    chk("bp_no_trunc", 32'(trunc_cnt), 32'(0));

    // truncation of a 6-word packet, then a normal packet on ch2
    push_pkt(1, 6, 8'hC0, 4, 1'b1);
    drain(40);
    chk("trunc_count", 32'(trunc_cnt), 32'(1));
    chk("trunc_tail_flushed", 32'(chq[1].size()), 32'(0));
    push_pkt(2, 2, 8'hD0, 4, 1'b1);
    drain(30);
    chk("trunc_count_after", 32'(trunc_cnt), 32'(1));

    // reset in the middle of a transfer, then rr restarts at ch0
    push_pkt(2, 4, 8'hE0, 4, 1'b1);
    run_until_left(2, 20);
    reset = 1'b1;
    refresh();
    #1;
    chk("midrst_rden", 32'(o_rden), 32'(0));
    cycle();
    chk("midrst_vld", 32'(o_vld), 32'(0));
    chk("midrst_eop", 32'(o_eop), 32'(0));
    chk("midrst_data", 32'(o_data), 32'(0));
    chk("midrst_grant", 32'(o_grant), 32'(0));
    chk("midrst_busy", 32'(o_busy), 32'(0));
    reset = 1'b0;
    chq[2].delete();
    sbq.delete();
    push_pkt(0, 1, 8'h40, 4, 1'b1);
    push_pkt(3, 1, 8'h30, 4, 1'b1);
    drain(30);

    // instance without header: one word, eop set
    sel   = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    push_pkt(3, 1, 8'h55, 1500, 1'b0);
    drain(30);
    chk("nohdr_fifo_empty", 32'(chq[3].size()), 32'(0));

    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single tx-buffer write port (data / datavld / eop / afull) of the packet processor between NUMCH requester channels. Each requester presents a first-word-fall-through packet FIFO head. The arbiter prepends an optional one-word channel-ID header and forwards the whole packet without interleaving. It obeys txbuffer_afull backpressure and truncates runaway packets at MAXPKTLEN words. It sits between the DUT-side channel FIFOs and the tx packet processor input, in the dutclk domain.

Parameters:
NUMCH, 4, number of requester channels (2..16)
DATAWIDTH, 8, data word width
MAXPKTLEN, 1500, maximum payload words forwarded per packet, header excluded
HDREN, 1, 1 = emit channel-ID header word before payload; 0 = no header

Ports:
dutclk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
ch_req  in  NUMCH  channel i holds at least one complete packet; level, held until granted
ch_data  in  NUMCH*DATAWIDTH  FWFT head word of channel i at bits [i*DATAWIDTH +: DATAWIDTH]
ch_datavld  in  NUMCH  head word of channel i valid
ch_eop  in  NUMCH  head word of channel i is last of packet
ch_rden  out  NUMCH  pop head word of channel i (combinational)
ch_grant  out  NUMCH  one-hot, channel currently owning the port (registered)
txbuffer_afull  in  1  tx buffer almost full; no new word may be issued while high
txbuffer_data  out  DATAWIDTH  word to tx buffer (registered)
txbuffer_datavld  out  1  txbuffer_data valid, one cycle per word
txbuffer_eop  out  1  last word of packet, coincident with datavld
trunc_pulse  out  1  one-cycle pulse when a packet is truncated
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, rr pointer=NUMCH-1, all registered outputs 0. ch_rden forced 0 while reset=1. Reset mid-packet abandons the packet with no eop emitted; the requester FIFO is flushed by its own reset.
- States: IDLE, HDR, XFER, FLUSH, GAP.
- IDLE: if any ch_req, select the first requesting channel searching upward from rr+1 with wrap (NUMCH-1 wraps to 0). Register ch_grant and go to HDR if HDREN=1, else XFER. No request: stay.
- HDR: when !afull, drive txbuffer_data=channel index zero-extended, datavld=1, eop=0, then go to XFER. When afull, hold with datavld=0.
- XFER: pop = ch_datavld[g] & !txbuffer_afull & !reset, and ch_rden[g]=pop. On pop, next cycle txbuffer_data=ch_data[g], datavld=1, eop=ch_eop[g]. Payload counter (16 bit) increments per pop and clears on state entry.
- XFER, pop with ch_eop[g]=1: go to GAP.
- XFER, pop with counter reaching MAXPKTLEN-1 and ch_eop=0: emit the word with eop forced 1, pulse trunc_pulse, go to FLUSH.
- XFER, ch_datavld[g]=0 mid-packet: wait; datavld=0 and no timeout.
- FLUSH: ch_rden[g]=ch_datavld[g] regardless of afull; nothing forwarded. On popping the eop word, go to GAP.
- GAP: one idle cycle. rr<=g, ch_grant<=0, go to IDLE. This guarantees at least 2 cycles between packets.
- Only ch_rden[g] can be 1. ch_req changes during a grant are ignored until IDLE.
- afull and ch_datavld both high: no pop. afull has no effect in IDLE or GAP.
- Latency: request in IDLE to first header datavld is 2 cycles with afull=0.

Test Plan:
- Single packet: NUMCH=4, ch2 req with 3 words 0xA1,0xA2,0xA3 (eop on 3rd) -> datavld sequence 0x02,0xA1,0xA2,0xA3. eop only on 0xA3. ch_grant=0100 during transfer. Header datavld 2 cycles after req.
- Round robin: ch0,ch1,ch3 request continuously with 2-word packets -> grant order 0,1,3,0,1,3. No interleaving. GAP cycle observed between packets.
- Backpressure: afull high for 5 cycles mid-packet -> no ch_rden and no datavld during those cycles. Transfer resumes with no lost or duplicated word; payload count unchanged.
- Truncation: MAXPKTLEN=4, ch1 6-word packet -> 4 payload words forwarded, eop on 4th, trunc_pulse once. Remaining 2 words popped without output. Next grant proceeds normally.
- Reset mid-XFER after 2 words: reset for 1 cycle -> all outputs 0 and busy=0 next cycle. rr=NUMCH-1, so a subsequent ch0 request is granted first.
- HDREN=0: ch3 1-word packet 0x55 with eop -> exactly one datavld word 0x55 with eop=1.
